mba_seq_mult: RTL and testbench
===============================

// Module: mba_seq_mult
// PURPOSE
//   Sequential radix-4 Modified Booth multiplier core. Consumes the MBA_A/MBA_B/MBA_val
//   operand pulse produced by the AXI-side bridge and returns the signed product on
//   MBA_out with a one-cycle MBA_out_val pulse. One Booth digit is retired per cycle;
//   the bridge sign-extends MBA_out to the AXI width.
// PARAMETERS
//   MBA_SIZE_IN   5   operand width, two's complement; >= 2
//   MBA_SIZE_OUT  10  product width; must equal 2*MBA_SIZE_IN (elaboration error otherwise)
//   localparam NDIG = ceil(MBA_SIZE_IN/2)  Booth digits (3 at default)
// PORTS
//   clock        in   1             single clock, all state on posedge
//   reset        in   1             synchronous, active-high
//   MBA_A        in   MBA_SIZE_IN   multiplicand, signed
//   MBA_B        in   MBA_SIZE_IN   multiplier, signed
//   MBA_val      in   1             operand strobe, sampled every cycle
//   MBA_out      out  MBA_SIZE_OUT  signed product, held until next result
//   MBA_out_val  out  1             one-cycle result strobe
//   busy         out  1             high while a multiply is in CALC
//   overrun      out  1             one-cycle pulse: MBA_val dropped because busy
// BEHAVIOUR
//   Reset: state=IDLE; MBA_out=0, MBA_out_val=0, busy=0, overrun=0; acc, idx, regs = 0.
//   FSM: IDLE -> CALC on MBA_val; CALC -> CALC while idx<NDIG-1; CALC -> DONE after
//     last digit; DONE -> CALC if MBA_val, else IDLE. DONE lasts exactly one cycle.
//   Accept (IDLE or DONE, MBA_val=1 in cycle T): latch A sign-extended to MBA_SIZE_OUT,
//     B sign-extended to 2*NDIG bits with implicit b[-1]=0; acc<=0; idx<=0.
//   CALC cycle i (T+1..T+NDIG): digit from {b[2i+1],b[2i],b[2i-1]}:
//     000/111->0, 001/010->+A, 011->+2A, 100->-2A, 101/110->-A;
//     acc <= acc + (pp << 2i), all arithmetic modulo 2^MBA_SIZE_OUT (no saturation;
//     full range fits, e.g. (-16)*(-16)=256).
//   Result: MBA_out <= acc_final and MBA_out_val=1 in cycle T+NDIG+1 (DONE);
//     latency NDIG+1 = 4 cycles at default. MBA_out_val low in every other cycle.
//   busy = (state==CALC). Back-to-back: MBA_val in the DONE cycle is accepted, so
//     throughput is one result per NDIG+1 cycles.
//   MBA_val while busy: operands ignored, current op unaffected, overrun=1 next cycle.
//   Simultaneous MBA_val and DONE: result strobe and accept both happen; MBA_out holds
//     the completed product, new op starts CALC next cycle.
//   Reset mid-operation: op abandoned, no MBA_out_val, all outputs to reset values.
//   No X propagation: MBA_A/MBA_B are sampled only on accept.
// STRUCTURE
//   Package mba_pkg: Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2), FSM state enum
//     (IDLE, CALC, DONE), function ndig(width) = (width+1)/2.
//   Sub-module booth_pp_gen (combinational): 3-bit window + extended A -> MBA_SIZE_OUT-bit
//     partial product, unshifted. Core holds FSM, idx counter, acc, operand registers.
// TESTING
//   A=3,  B=5, MBA_val at T        -> MBA_out=0x00F, MBA_out_val only at T+4, busy T+1..T+3
//   A=-16,B=-16                    -> MBA_out=0x100 (256); A=-16,B=15 -> 0x310 (-240)
//   A=7,  B=-3 then A=0,B=-11 in DONE cycle -> 0x3EB at T+4, 0x000 at T+8, no overrun
//   MBA_val with A=1,B=1 at T+2 of op 2*2 -> overrun pulse at T+3, result 0x004 only
//   reset at T+2 of op 5*5          -> no MBA_out_val, MBA_out=0, next op 1*-1 -> 0x3FF
//   Sweep all 1024 operand pairs vs. signed reference model, 1 op per 4 cycles

Source files
------------

// File: rtl/mba_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit/state enums and helpers.
package mba_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_dig_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Radix-4 retires two multiplier bits per digit.
  function automatic int ndig(input int width);
    return (width + 1) / 2;
  endfunction

  function automatic booth_dig_e booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial product: 3-bit multiplier window selects 0/+-A/+-2A.
// Result is unshifted; the caller aligns it to the digit position.
module booth_pp_gen
  import mba_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   win,
  input  logic [W-1:0] a_ext,
  output logic [W-1:0] pp
);

  always_comb begin
    pp = '0;
    case (booth_decode(win))
      POS1:    pp = a_ext;
      POS2:    pp = a_ext << 1;
      NEG1:    pp = -a_ext;
      NEG2:    pp = -(a_ext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/mba_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle; result NDIG+1 cycles after accept.
// No backpressure: operands arriving while busy are dropped and flagged on overrun.
module mba_seq_mult
  import mba_pkg::*;
#(
  parameter int MBA_SIZE_IN  = 5,
  parameter int MBA_SIZE_OUT = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MBA_SIZE_IN-1:0]  MBA_A,
  input  logic [MBA_SIZE_IN-1:0]  MBA_B,
  input  logic                    MBA_val,
  output logic [MBA_SIZE_OUT-1:0] MBA_out,
  output logic                    MBA_out_val,
  output logic                    busy,
  output logic                    overrun
);

  localparam int NDIG = ndig(MBA_SIZE_IN);
  localparam int BW   = 2 * NDIG;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (MBA_SIZE_OUT != 2 * MBA_SIZE_IN) begin : g_bad_width
    $error("mba_seq_mult: MBA_SIZE_OUT must equal 2*MBA_SIZE_IN");
  end
  if (MBA_SIZE_IN < 2) begin : g_bad_in
    $error("mba_seq_mult: MBA_SIZE_IN must be at least 2");
  end

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [MBA_SIZE_OUT-1:0] a_q, a_d;
  logic [BW:0]             b_q, b_d;
  logic [MBA_SIZE_OUT-1:0] acc_q, acc_d;
  logic [MBA_SIZE_OUT-1:0] out_q, out_d;
  logic                    out_val_q, out_val_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic [2:0]              win;
  logic [MBA_SIZE_OUT-1:0] pp;
  logic [MBA_SIZE_OUT-1:0] pp_sh;
  logic [MBA_SIZE_OUT-1:0] acc_sum;
  logic                    accept;

  // b_q carries the implicit b[-1]=0 in bit 0, so digit i's window starts at bit 2i.
  assign win     = 3'(b_q >> (2 * idx_q));
  assign pp_sh   = pp << (2 * idx_q);
  assign acc_sum = acc_q + pp_sh;
  assign accept  = MBA_val && (state_q != CALC);

  booth_pp_gen #(.W(MBA_SIZE_OUT)) u_pp_gen (
    .win   (win),
    .a_ext (a_q),
    .pp    (pp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    out_d     = out_q;
    out_val_d = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      CALC: begin
        acc_d     = acc_sum;
        overrun_d = MBA_val;
        if (idx_q == IW'(NDIG - 1)) begin
          state_d   = DONE;
          out_d     = acc_sum;
          out_val_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new operand pair may start in the same cycle the previous result is presented.
    if (accept) begin
      state_d = CALC;
      idx_d   = '0;
      acc_d   = '0;
      a_d     = MBA_SIZE_OUT'($signed(MBA_A));
      b_d     = {BW'($signed(MBA_B)), 1'b0};
    end

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      out_val_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      out_val_q <= out_val_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign MBA_out     = out_q;
  assign MBA_out_val = out_val_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mba_seq_mult.sv
// Directed and exhaustive bench for mba_seq_mult with a product scoreboard.
module tb_mba_seq_mult;

  logic       clock;
  logic       reset;
  logic [4:0] MBA_A;
  logic [4:0] MBA_B;
  logic       MBA_val;
  logic [9:0] MBA_out;
  logic       MBA_out_val;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  mba_seq_mult #(.MBA_SIZE_IN(5), .MBA_SIZE_OUT(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .MBA_A       (MBA_A),
    .MBA_B       (MBA_B),
    .MBA_val     (MBA_val),
    .MBA_out     (MBA_out),
    .MBA_out_val (MBA_out_val),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] ref_mul(input logic [4:0] a, input logic [4:0] b);
    int ia;
    int ib;
    int p;
    ia = int'($signed(a));
    ib = int'($signed(b));
    p  = ia * ib;
    return p[9:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then sample outputs away from the edge and drain the scoreboard.
  task automatic tick();
    logic [9:0] exp;
    @(posedge clock);
    #1;
    if (MBA_out_val === 1'b1) begin
      if (sb.size() == 0) begin
        chk("out_val_unexpected", 32'(MBA_out_val), 32'd0);
      end else begin
        exp = sb.pop_front();
        chk("product", 32'(MBA_out), 32'(exp));
      end
    end
  endtask

  // Present one operand pair for a single cycle; returns in cycle T+1.
  task automatic go(input logic [4:0] a, input logic [4:0] b, input bit expect_result);
    MBA_A   = a;
    MBA_B   = b;
    MBA_val = 1'b1;
    if (expect_result) sb.push_back(ref_mul(a, b));
    tick();
    MBA_val = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    MBA_A   = '0;
    MBA_B   = '0;
    MBA_val = 1'b0;
    tick();
    tick();
    chk("rst_out", 32'(MBA_out), 32'd0);
    chk("rst_out_val", 32'(MBA_out_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // 3*5: exact latency and busy window
    go(5'd3, 5'd5, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("lat_busy_t%0d", i), 32'(busy), 32'd1);
      chk($sformatf("lat_vld_t%0d", i), 32'(MBA_out_val), 32'd0);
      tick();
    end
    chk("lat_vld_t4", 32'(MBA_out_val), 32'd1);
    chk("lat_out_t4", 32'(MBA_out), 32'h00F);
    chk("lat_busy_t4", 32'(busy), 32'd0);
    tick();
    chk("lat_vld_t5", 32'(MBA_out_val), 32'd0);
    chk("lat_hold_t5", 32'(MBA_out), 32'h00F);

    // Range extremes
    go(5'h10, 5'h10, 1'b1);
    tick(); tick(); tick();
    chk("neg16_sq", 32'(MBA_out), 32'h100);
    tick();
    go(5'h10, 5'h0F, 1'b1);
    tick(); tick(); tick();
    chk("neg16_x15", 32'(MBA_out), 32'h310);
    tick();

    // Back-to-back: second op accepted in the DONE cycle
    go(5'd7, 5'h1D, 1'b1);
    tick(); tick(); tick();
    chk("b2b_first", 32'(MBA_out), 32'h3EB);
    go(5'd0, 5'h15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_no_overrun_%0d", i), 32'(overrun), 32'd0);
      chk($sformatf("b2b_busy_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    chk("b2b_second_vld", 32'(MBA_out_val), 32'd1);
    chk("b2b_second", 32'(MBA_out), 32'h000);
    chk("b2b_no_overrun_done", 32'(overrun), 32'd0);
    tick();

    // Operands while busy are dropped and flagged
    go(5'd2, 5'd2, 1'b1);
    tick();
    MBA_A   = 5'd1;
    MBA_B   = 5'd1;
    MBA_val = 1'b1;
    chk("ovr_before", 32'(overrun), 32'd0);
    tick();
    MBA_val = 1'b0;
    chk("ovr_pulse", 32'(overrun), 32'd1);
    tick();
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_result", 32'(MBA_out), 32'h004);
    tick();
    chk("ovr_single_result", 32'(MBA_out_val), 32'd0);
    chk("ovr_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation abandons the op
    go(5'd5, 5'd5, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out", 32'(MBA_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vld", 32'(MBA_out_val), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_quiet_out", 32'(MBA_out), 32'd0);
    go(5'd1, 5'h1F, 1'b1);
    tick(); tick(); tick();
    chk("post_rst", 32'(MBA_out), 32'h3FF);
    tick();

    // Exhaustive sweep at full throughput
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        go(5'(a), 5'(b), 1'b1);
        tick(); tick(); tick();
      end
    end
    tick(); tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
